hamming_rx_ctrl: RTL and testbench
==================================

HAMMING_RX_CTRL -- requirements
Module: hamming_rx_ctrl

Interface
REQ-001 SHALL have parameter PKT_W, default 16: SPI packet width in bits.
REQ-002 SHALL have parameter DATA_W, default 11: decoded payload width.
REQ-003 SHALL have parameter CNT_W, default 8: error-counter width.
REQ-004 SHALL have port clk, input, 1: single system clock; all logic on posedge, except the decoder, which is negedge-internal.
REQ-005 SHALL have port rst_n, input, 1: reset, asynchronous and active-low.
REQ-006 SHALL have ports spi_sclk, spi_mosi and spi_cs_n, all inputs, 1 each: asynchronous SPI mode-0 receive pins; cs_n is active-low.
REQ-007 SHALL have port dec_packet, output, PKT_W: packet driven to the hamming decoder.
REQ-008 SHALL have port dec_state, output, 4: step index driven to the hamming decoder.
REQ-009 SHALL have port dec_data, input, DATA_W: corrected payload from the decoder.
REQ-010 SHALL have port dec_double_err, input, 1: uncorrectable-error flag from the decoder.
REQ-011 SHALL have port rx_data, output, DATA_W: captured payload.
REQ-012 SHALL have port rx_dbl_err, output, 1: double-error flag qualifying rx_data.
REQ-013 SHALL have port rx_valid, output, 1: rx_data/rx_dbl_err valid.
REQ-014 SHALL have port rx_ready, input, 1: consumer accepts; a transfer occurs when rx_valid and rx_ready are both 1.
REQ-015 SHALL have port frame_err, output, 1: one-cycle pulse flagging a bad frame length.
REQ-016 SHALL have port overrun, output, 1: one-cycle pulse flagging a dropped packet.
REQ-017 SHALL have port dbl_err_cnt, output, CNT_W: saturating count of double errors.

Function
REQ-018 SHALL synchronise spi_sclk, spi_mosi and spi_cs_n through 2 flip-flops each, and detect sclk rising and cs_n rising/falling edges on the synchronised copies.
REQ-019 SHALL, on cs_n falling, clear the bit counter and shift register.
REQ-020 SHALL, on each sclk rise while cs_n is low, shift mosi into the LSB (MSB first) and increment a saturating 5-bit bit counter.
REQ-021 SHALL, on cs_n rising, treat a bit count of exactly PKT_W as packet-complete; any other count SHALL discard the packet and pulse frame_err for 1 cycle.
REQ-022 SHALL implement the FSM states IDLE, SWEEP, SETTLE and HOLD.
REQ-023 SHALL transition IDLE -> SWEEP on packet-complete, latch the shift register into dec_packet, and keep dec_packet stable until the next SWEEP entry.
REQ-024 SHALL, in SWEEP, drive dec_state 1,2,...,15,0, one value per clk (16 cycles), then go to SETTLE.
REQ-025 SHALL hold dec_state 0 in SETTLE for 1 cycle, then capture dec_data and dec_double_err into rx_data and rx_dbl_err, set rx_valid, and go to HOLD.
REQ-026 SHALL drive dec_state 0 in IDLE and HOLD.
REQ-027 SHALL, in HOLD, keep rx_valid, rx_data and rx_dbl_err stable until handshake; on handshake, clear rx_valid and return to IDLE in the same edge.
REQ-028 SHALL give a latency of 18 clk from the packet-complete cycle to rx_valid high.
REQ-029 SHALL, when packet-complete occurs in SWEEP, SETTLE or HOLD, drop the new packet, pulse overrun for 1 cycle and leave the current decode undisturbed.
REQ-030 SHALL continue SPI reception in every FSM state.
REQ-031 SHALL, when packet-complete and the HOLD handshake occur in the same cycle, accept the packet and go directly to SWEEP with no overrun.
REQ-032 SHALL increment dbl_err_cnt by 1 at capture when dec_double_err is 1, saturating at 2^CNT_W-1 with no wrap.

Reset
REQ-033 SHALL, while rst_n is low, force asynchronously: FSM to IDLE, dec_state 0, dec_packet 0, rx_data 0, rx_dbl_err 0, rx_valid 0, frame_err 0, overrun 0, dbl_err_cnt 0, bit counter 0, shift register 0, sync flops 0, with cs_n sync flops at 1.
REQ-034 SHALL discard any in-progress frame or decode when reset is asserted mid-operation, with no pulse on deassertion.

Structure
REQ-035 SHALL place the FSM state typedef and the constants SWEEP_LEN=16 and SYNC_STAGES=2 in shared package hamming_pkg.
REQ-036 SHALL use one sub-module, spi_rx_shift (synchroniser, edge detect, shift register, bit counter, complete/frame-error outputs), instantiated once; the hamming decoder itself is instantiated outside this block.

Verification
REQ-037 SHALL cover: 16-bit clean codeword for data 11'h5A5, rx_ready=1 -> rx_valid 18 clk after complete, rx_data=11'h5A5, rx_dbl_err=0.
REQ-038 SHALL cover: same codeword with bit 9 flipped -> rx_data=11'h5A5, rx_dbl_err=0, dbl_err_cnt unchanged.
REQ-039 SHALL cover: bits 3 and 10 flipped -> rx_dbl_err=1, dbl_err_cnt=1; 300 such packets -> dbl_err_cnt=255.
REQ-040 SHALL cover: 15 and 17 sclk edges inside one cs_n window -> frame_err pulse each, rx_valid stays 0.
REQ-041 SHALL cover: rx_ready=0, second packet completes during HOLD -> overrun pulse, rx_data keeps first value; complete coincident with handshake -> no overrun, second packet decoded.
REQ-042 SHALL cover: rst_n low at SWEEP step 7 -> all outputs 0 asynchronously, next clean packet decodes correctly.

Source files
------------

// File: rtl/hamming_pkg.sv
// ----------------------------------------------------------------------------
// hamming_pkg
// Shared definitions for the hamming receive controller slice.
//   state_t        : controller FSM state encoding (IDLE/SWEEP/SETTLE/HOLD)
//   SWEEP_LEN      : number of decoder step cycles driven per packet
//   SYNC_STAGES    : depth of the SPI pin synchronisers
// ----------------------------------------------------------------------------
package hamming_pkg;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE   = 2'd0;
    localparam state_t ST_SWEEP  = 2'd1;
    localparam state_t ST_SETTLE = 2'd2;
    localparam state_t ST_HOLD   = 2'd3;

    localparam int SWEEP_LEN   = 16;
    localparam int SYNC_STAGES = 2;

endpackage

// File: rtl/spi_rx_shift.sv
// ----------------------------------------------------------------------------
// spi_rx_shift
// SPI mode-0 receive front end running in the clk domain.
//   clk, rst_n    : system clock, asynchronous active-low reset
//   sclk_i        : raw SPI clock pin (asynchronous)
//   mosi_i        : raw SPI data pin (asynchronous)
//   cs_n_i        : raw SPI chip select pin, active low (asynchronous)
//   pkt_o         : shift register contents (MSB first received)
//   complete_o    : combinational, high for the one cycle in which cs_n rise
//                   is seen with exactly PKT_W bits received
//   frame_err_o   : registered one-cycle pulse after a cs_n rise with any
//                   other bit count
// ----------------------------------------------------------------------------
import hamming_pkg::*;

module spi_rx_shift #(
    parameter int PKT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             sclk_i,
    input  logic             mosi_i,
    input  logic             cs_n_i,
    output logic [PKT_W-1:0] pkt_o,
    output logic             complete_o,
    output logic             frame_err_o
);

    localparam logic [4:0] CNT_PKT = 5'(PKT_W);
    localparam logic [4:0] CNT_MAX = 5'h1f;

    logic [SYNC_STAGES-1:0] sclk_sync_q;
    logic [SYNC_STAGES-1:0] mosi_sync_q;
    logic [SYNC_STAGES-1:0] cs_sync_q;
    logic                   sclk_prev_q;
    logic                   cs_prev_q;

    logic [4:0]       bit_cnt_q, bit_cnt_d;
    logic [PKT_W-1:0] shift_q, shift_d;
    logic             frame_err_q, frame_err_d;

    logic sclk_s, mosi_s, cs_s;
    logic sclk_rise, cs_rise, cs_fall;

    assign sclk_s = sclk_sync_q[SYNC_STAGES-1];
    assign mosi_s = mosi_sync_q[SYNC_STAGES-1];
    assign cs_s   = cs_sync_q[SYNC_STAGES-1];

    assign sclk_rise = sclk_s & ~sclk_prev_q;
    assign cs_rise   = cs_s & ~cs_prev_q;
    assign cs_fall   = ~cs_s & cs_prev_q;

    // cs_n synchroniser and its edge history reset to the idle (high) level
    // so that leaving reset never looks like a frame boundary.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sclk_sync_q <= '0;
            mosi_sync_q <= '0;
            cs_sync_q   <= '1;
            sclk_prev_q <= 1'b0;
            cs_prev_q   <= 1'b1;
            bit_cnt_q   <= '0;
            shift_q     <= '0;
            frame_err_q <= 1'b0;
        end else begin
            sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], sclk_i};
            mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], mosi_i};
            cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], cs_n_i};
            sclk_prev_q <= sclk_s;
            cs_prev_q   <= cs_s;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            frame_err_q <= frame_err_d;
        end
    end

    always_comb begin
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        frame_err_d = 1'b0;
        complete_o  = 1'b0;

        if (cs_fall) begin
            bit_cnt_d = '0;
            shift_d   = '0;
        end else if (sclk_rise && !cs_s) begin
            shift_d = {shift_q[PKT_W-2:0], mosi_s};
            // Saturate so a very long frame cannot wrap back to PKT_W.
            if (bit_cnt_q != CNT_MAX) begin
                bit_cnt_d = bit_cnt_q + 5'd1;
            end
        end

        if (cs_rise) begin
            if (bit_cnt_q == CNT_PKT) begin
                complete_o = 1'b1;
            end else begin
                frame_err_d = 1'b1;
            end
        end
    end

    assign pkt_o       = shift_q;
    assign frame_err_o = frame_err_q;

endmodule

// File: rtl/hamming_rx_ctrl.sv
// ----------------------------------------------------------------------------
// hamming_rx_ctrl
// Receives SPI packets, sweeps an external hamming decoder through its 16
// step indices, and presents the corrected payload on a valid/ready port.
//   clk, rst_n       : system clock, asynchronous active-low reset
//   spi_sclk/mosi/cs_n : asynchronous SPI mode-0 receive pins
//   dec_packet       : packet presented to the decoder, stable per decode
//   dec_state        : decoder step index (1..15,0 during a sweep, else 0)
//   dec_data         : corrected payload returned by the decoder
//   dec_double_err   : uncorrectable-error flag returned by the decoder
//   rx_data/rx_dbl_err : captured payload and its double-error qualifier
//   rx_valid/rx_ready  : a transfer happens on a clk edge where both are 1;
//                        rx_valid and its data stay stable until then
//   frame_err        : one-cycle pulse, frame ended with a wrong bit count
//   overrun          : one-cycle pulse, a complete packet was dropped
//   dbl_err_cnt      : saturating count of captured double errors
// ----------------------------------------------------------------------------
import hamming_pkg::*;

module hamming_rx_ctrl #(
    parameter int PKT_W  = 16,
    parameter int DATA_W = 11,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              spi_sclk,
    input  logic              spi_mosi,
    input  logic              spi_cs_n,
    output logic [PKT_W-1:0]  dec_packet,
    output logic [3:0]        dec_state,
    input  logic [DATA_W-1:0] dec_data,
    input  logic              dec_double_err,
    output logic [DATA_W-1:0] rx_data,
    output logic              rx_dbl_err,
    output logic              rx_valid,
    input  logic              rx_ready,
    output logic              frame_err,
    output logic              overrun,
    output logic [CNT_W-1:0]  dbl_err_cnt
);

    localparam logic [4:0]       STEP_LAST = 5'(SWEEP_LEN - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [PKT_W-1:0] pkt;
    logic             complete;

    state_t            state_q, state_d;
    logic [4:0]        step_q, step_d;
    logic [3:0]        dec_state_q, dec_state_d;
    logic [PKT_W-1:0]  dec_packet_q, dec_packet_d;
    logic [DATA_W-1:0] rx_data_q, rx_data_d;
    logic              rx_dbl_err_q, rx_dbl_err_d;
    logic              rx_valid_q, rx_valid_d;
    logic              overrun_q, overrun_d;
    logic [CNT_W-1:0]  dbl_cnt_q, dbl_cnt_d;
    logic              handshake;

    spi_rx_shift #(
        .PKT_W (PKT_W)
    ) u_spi_rx_shift (
        .clk         (clk),
        .rst_n       (rst_n),
        .sclk_i      (spi_sclk),
        .mosi_i      (spi_mosi),
        .cs_n_i      (spi_cs_n),
        .pkt_o       (pkt),
        .complete_o  (complete),
        .frame_err_o (frame_err)
    );

    assign handshake = rx_valid_q & rx_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            step_q       <= '0;
            dec_state_q  <= '0;
            dec_packet_q <= '0;
            rx_data_q    <= '0;
            rx_dbl_err_q <= 1'b0;
            rx_valid_q   <= 1'b0;
            overrun_q    <= 1'b0;
            dbl_cnt_q    <= '0;
        end else begin
            state_q      <= state_d;
            step_q       <= step_d;
            dec_state_q  <= dec_state_d;
            dec_packet_q <= dec_packet_d;
            rx_data_q    <= rx_data_d;
            rx_dbl_err_q <= rx_dbl_err_d;
            rx_valid_q   <= rx_valid_d;
            overrun_q    <= overrun_d;
            dbl_cnt_q    <= dbl_cnt_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        step_d       = step_q;
        dec_state_d  = dec_state_q;
        dec_packet_d = dec_packet_q;
        rx_data_d    = rx_data_q;
        rx_dbl_err_d = rx_dbl_err_q;
        rx_valid_d   = rx_valid_q;
        overrun_d    = 1'b0;
        dbl_cnt_d    = dbl_cnt_q;

        case (state_q)
            ST_IDLE: begin
                if (complete) begin
                    state_d      = ST_SWEEP;
                    step_d       = '0;
                    dec_state_d  = 4'd1;
                    dec_packet_d = pkt;
                end
            end
            ST_SWEEP: begin
                // dec_state runs one ahead of step and wraps 15 -> 0, so the
                // final sweep cycle already presents step index 0.
                if (step_q == STEP_LAST) begin
                    state_d     = ST_SETTLE;
                    dec_state_d = 4'd0;
                end else begin
                    step_d      = step_q + 5'd1;
                    dec_state_d = dec_state_q + 4'd1;
                end
            end
            ST_SETTLE: begin
                state_d      = ST_HOLD;
                dec_state_d  = 4'd0;
                rx_data_d    = dec_data;
                rx_dbl_err_d = dec_double_err;
                rx_valid_d   = 1'b1;
                if (dec_double_err && (dbl_cnt_q != {CNT_W{1'b1}})) begin
                    dbl_cnt_d = dbl_cnt_q + CNT_ONE;
                end
            end
            default: begin  // ST_HOLD
                dec_state_d = 4'd0;
                if (handshake) begin
                    rx_valid_d = 1'b0;
                    // A packet finishing on the handshake edge is taken
                    // straight into a new sweep rather than dropped.
                    if (complete) begin
                        state_d      = ST_SWEEP;
                        step_d       = '0;
                        dec_state_d  = 4'd1;
                        dec_packet_d = pkt;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
        endcase

        if (complete && (state_q != ST_IDLE) && !((state_q == ST_HOLD) && handshake)) begin
            overrun_d = 1'b1;
        end
    end

    assign dec_state   = dec_state_q;
    assign dec_packet  = dec_packet_q;
    assign rx_data     = rx_data_q;
    assign rx_dbl_err  = rx_dbl_err_q;
    assign rx_valid    = rx_valid_q;
    assign overrun     = overrun_q;
    assign dbl_err_cnt = dbl_cnt_q;

endmodule

// File: tb/tb_hamming_rx_ctrl.sv
// ----------------------------------------------------------------------------
// tb_hamming_rx_ctrl
// Directed bench for hamming_rx_ctrl. A behavioural extended-hamming (15,11)
// plus overall parity decoder accumulates the syndrome over the dec_state
// sweep on clk negedges, standing in for the external decoder.
// Codeword layout: packet bit p (1..15) is hamming position p, bit 0 is the
// overall even parity. Data 11'h5A5 encodes to 16'hB44B, data 0 to 16'h0000.
// ----------------------------------------------------------------------------
module tb_hamming_rx_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        spi_sclk = 1'b0;
    logic        spi_mosi = 1'b0;
    logic        spi_cs_n = 1'b1;
    logic [15:0] dec_packet;
    logic [3:0]  dec_state;
    logic [10:0] dec_data = '0;
    logic        dec_double_err = 1'b0;
    logic [10:0] rx_data;
    logic        rx_dbl_err;
    logic        rx_valid;
    logic        rx_ready = 1'b0;
    logic        frame_err;
    logic        overrun;
    logic [7:0]  dbl_err_cnt;

    int checks = 0;
    int errors = 0;

    localparam logic [15:0] CW_5A5 = 16'hB44B;
    localparam logic [15:0] CW_000 = 16'h0000;

    hamming_rx_ctrl #(.PKT_W(16), .DATA_W(11), .CNT_W(8)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .spi_sclk       (spi_sclk),
        .spi_mosi       (spi_mosi),
        .spi_cs_n       (spi_cs_n),
        .dec_packet     (dec_packet),
        .dec_state      (dec_state),
        .dec_data       (dec_data),
        .dec_double_err (dec_double_err),
        .rx_data        (rx_data),
        .rx_dbl_err     (rx_dbl_err),
        .rx_valid       (rx_valid),
        .rx_ready       (rx_ready),
        .frame_err      (frame_err),
        .overrun        (overrun),
        .dbl_err_cnt    (dbl_err_cnt)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- decoder model ----------------
    logic [3:0]  syn_acc = '0;
    logic        par_acc = 1'b0;
    logic [3:0]  prev_ds = '0;
    logic [15:0] cw_fix;
    logic        full_par;

    always @(negedge clk) begin
        if (dec_state == 4'd1) begin
            syn_acc = dec_packet[1] ? 4'd1 : 4'd0;
            par_acc = dec_packet[1];
        end else if (dec_state != 4'd0) begin
            if (dec_packet[dec_state]) syn_acc = syn_acc ^ dec_state;
            par_acc = par_acc ^ dec_packet[dec_state];
        end else if (prev_ds == 4'd15) begin
            full_par = par_acc ^ dec_packet[0];
            cw_fix   = dec_packet;
            if (syn_acc != 4'd0 && full_par) cw_fix[syn_acc] = ~cw_fix[syn_acc];
            dec_double_err = (syn_acc != 4'd0) && !full_par;
            dec_data = {cw_fix[15:9], cw_fix[7:5], cw_fix[3]};
        end
        prev_ds = dec_state;
    end

    // ---------------- watchdog ----------------
    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // ---------------- driver tasks ----------------
    // Sends the low nbits of word MSB first; returns on the negedge where
    // cs_n is driven high.
    task automatic spi_frame(input logic [31:0] word, input int nbits);
        spi_cs_n = 1'b0;
        repeat (4) @(negedge clk);
        for (int i = nbits - 1; i >= 0; i--) begin
            spi_mosi = word[i];
            repeat (2) @(negedge clk);
            spi_sclk = 1'b1;
            repeat (2) @(negedge clk);
            spi_sclk = 1'b0;
        end
        repeat (2) @(negedge clk);
        spi_cs_n = 1'b1;
    endtask

    // Counts posedges until rx_valid is seen high at a negedge.
    task automatic wait_rx(output int k);
        k = 0;
        for (int c = 1; c <= 60; c++) begin
            @(posedge clk);
            @(negedge clk);
            if (rx_valid) begin
                k = c;
                break;
            end
        end
        checks++;
        if (k == 0) begin
            errors++;
            $display("FAIL rx_timeout: rx_valid not seen within 60 cycles, required within 60");
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset;
        repeat (3) @(negedge clk);
        checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL rst_rx_valid: got %b required 0", rx_valid); end
        checks++; if (rx_data !== 11'h000) begin errors++; $display("FAIL rst_rx_data: got %h required 000", rx_data); end
        checks++; if (dec_state !== 4'd0) begin errors++; $display("FAIL rst_dec_state: got %0d required 0", dec_state); end
        checks++; if (dec_packet !== 16'h0000) begin errors++; $display("FAIL rst_dec_packet: got %h required 0000", dec_packet); end
        checks++; if (dbl_err_cnt !== 8'd0) begin errors++; $display("FAIL rst_cnt: got %0d required 0", dbl_err_cnt); end
        checks++; if ({frame_err, overrun, rx_dbl_err} !== 3'b000) begin errors++; $display("FAIL rst_pulses: got %b required 000", {frame_err, overrun, rx_dbl_err}); end
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_clean;
        int k;
        int nz;
        rx_ready = 1'b1;
        spi_frame({16'h0, CW_5A5}, 16);
        k = 0;
        nz = 0;
        for (int c = 1; c <= 60; c++) begin
            @(posedge clk);
            @(negedge clk);
            if (dec_state != 4'd0) nz++;
            if (rx_valid) begin
                k = c;
                break;
            end
        end
        // 2 sync edges bring cs_n rise to complete, then 18 to rx_valid.
        checks++; if (k != 20) begin errors++; $display("FAIL clean_latency: got %0d required 20", k); end
        checks++; if (nz != 15) begin errors++; $display("FAIL clean_sweep_nonzero: got %0d required 15", nz); end
        checks++; if (rx_data !== 11'h5A5) begin errors++; $display("FAIL clean_data: got %h required 5a5", rx_data); end
        checks++; if (rx_dbl_err !== 1'b0) begin errors++; $display("FAIL clean_dbl: got %b required 0", rx_dbl_err); end
        checks++; if (dec_packet !== CW_5A5) begin errors++; $display("FAIL clean_packet: got %h required b44b", dec_packet); end
        checks++; if (dec_state !== 4'd0) begin errors++; $display("FAIL clean_hold_state: got %0d required 0", dec_state); end
        @(posedge clk);
        @(negedge clk);
        checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL clean_handshake: got %b required 0", rx_valid); end
    endtask

    task automatic test_single_err;
        int k;
        rx_ready = 1'b1;
        spi_frame({16'h0, CW_5A5 ^ 16'h0200}, 16);
        wait_rx(k);
        checks++; if (rx_data !== 11'h5A5) begin errors++; $display("FAIL single_data: got %h required 5a5", rx_data); end
        checks++; if (rx_dbl_err !== 1'b0) begin errors++; $display("FAIL single_dbl: got %b required 0", rx_dbl_err); end
        checks++; if (dbl_err_cnt !== 8'd0) begin errors++; $display("FAIL single_cnt: got %0d required 0", dbl_err_cnt); end
    endtask

    task automatic test_double_err;
        int k;
        rx_ready = 1'b1;
        spi_frame({16'h0, CW_5A5 ^ 16'h0408}, 16);
        wait_rx(k);
        checks++; if (rx_dbl_err !== 1'b1) begin errors++; $display("FAIL double_dbl: got %b required 1", rx_dbl_err); end
        checks++; if (dbl_err_cnt !== 8'd1) begin errors++; $display("FAIL double_cnt: got %0d required 1", dbl_err_cnt); end
        for (int i = 0; i < 300; i++) begin
            spi_frame({16'h0, CW_5A5 ^ 16'h0408}, 16);
            wait_rx(k);
            if (i == 198) begin
                checks++; if (dbl_err_cnt !== 8'd200) begin errors++; $display("FAIL double_cnt200: got %0d required 200", dbl_err_cnt); end
            end
        end
        checks++; if (dbl_err_cnt !== 8'd255) begin errors++; $display("FAIL double_saturate: got %0d required 255", dbl_err_cnt); end
        checks++; if (rx_dbl_err !== 1'b1) begin errors++; $display("FAIL double_dbl_last: got %b required 1", rx_dbl_err); end
        repeat (3) @(negedge clk);
    endtask

    task automatic test_frame_err;
        int fe;
        int vs;
        int lens[2] = '{15, 17};
        rx_ready = 1'b1;
        foreach (lens[j]) begin
            spi_frame(32'h1ABCD, lens[j]);
            fe = 0;
            vs = 0;
            for (int c = 0; c < 30; c++) begin
                @(posedge clk);
                @(negedge clk);
                if (frame_err) fe++;
                if (rx_valid) vs++;
            end
            checks++; if (fe != 1) begin errors++; $display("FAIL frame_err_len%0d: got %0d pulse cycles required 1", lens[j], fe); end
            checks++; if (vs != 0) begin errors++; $display("FAIL frame_valid_len%0d: got %0d valid cycles required 0", lens[j], vs); end
        end
    endtask

    task automatic test_reset_mid;
        int k;
        int bad;
        rx_ready = 1'b1;
        spi_frame({16'h0, CW_5A5}, 16);
        k = 0;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            if (dec_state == 4'd7) begin
                k = c;
                break;
            end
        end
        checks++; if (k == 0) begin errors++; $display("FAIL mid_reach_step7: got no step 7 required step 7 within 40 cycles"); end
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if (dec_state !== 4'd0) begin errors++; $display("FAIL mid_rst_state: got %0d required 0", dec_state); end
        checks++; if (dec_packet !== 16'h0000) begin errors++; $display("FAIL mid_rst_packet: got %h required 0000", dec_packet); end
        checks++; if (dbl_err_cnt !== 8'd0) begin errors++; $display("FAIL mid_rst_cnt: got %0d required 0", dbl_err_cnt); end
        checks++; if (rx_data !== 11'h000) begin errors++; $display("FAIL mid_rst_data: got %h required 000", rx_data); end
        checks++; if ({rx_valid, rx_dbl_err, frame_err, overrun} !== 4'b0000) begin errors++; $display("FAIL mid_rst_flags: got %b required 0000", {rx_valid, rx_dbl_err, frame_err, overrun}); end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        bad = 0;
        for (int c = 0; c < 30; c++) begin
            @(posedge clk);
            @(negedge clk);
            if (rx_valid || frame_err || overrun || dec_state != 4'd0) bad++;
        end
        checks++; if (bad != 0) begin errors++; $display("FAIL mid_release_quiet: got %0d active cycles required 0", bad); end
        spi_frame({16'h0, CW_5A5}, 16);
        wait_rx(k);
        checks++; if (rx_data !== 11'h5A5) begin errors++; $display("FAIL mid_after_data: got %h required 5a5", rx_data); end
        checks++; if (rx_dbl_err !== 1'b0) begin errors++; $display("FAIL mid_after_dbl: got %b required 0", rx_dbl_err); end
        repeat (3) @(negedge clk);
    endtask

    task automatic test_overrun;
        int k;
        int ov;
        int lost;
        int changed;
        rx_ready = 1'b0;
        spi_frame({16'h0, CW_5A5}, 16);
        wait_rx(k);
        checks++; if (rx_data !== 11'h5A5) begin errors++; $display("FAIL ovr_first_data: got %h required 5a5", rx_data); end

        // Second packet lands while the first waits in HOLD.
        spi_frame({16'h0, CW_000}, 16);
        ov = 0;
        lost = 0;
        changed = 0;
        for (int c = 0; c < 30; c++) begin
            @(posedge clk);
            @(negedge clk);
            if (overrun) ov++;
            if (!rx_valid) lost++;
            if (rx_data !== 11'h5A5) changed++;
        end
        checks++; if (ov != 1) begin errors++; $display("FAIL ovr_pulse: got %0d pulse cycles required 1", ov); end
        checks++; if (lost != 0) begin errors++; $display("FAIL ovr_valid_kept: got %0d low cycles required 0", lost); end
        checks++; if (changed != 0) begin errors++; $display("FAIL ovr_data_kept: got %0d changed cycles required 0", changed); end
        checks++; if (dec_packet !== CW_5A5) begin errors++; $display("FAIL ovr_packet_kept: got %h required b44b", dec_packet); end

        // Third packet completes on the same edge as the handshake.
        spi_frame({16'h0, CW_000}, 16);
        @(posedge clk);
        @(negedge clk);
        @(posedge clk);
        @(negedge clk);
        rx_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rx_ready = 1'b0;
        checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL coinc_handshake: got %b required 0", rx_valid); end
        checks++; if (dec_state !== 4'd1) begin errors++; $display("FAIL coinc_sweep_entry: got %0d required 1", dec_state); end
        checks++; if (dec_packet !== CW_000) begin errors++; $display("FAIL coinc_packet: got %h required 0000", dec_packet); end
        ov = (overrun === 1'b1) ? 1 : 0;
        k = 0;
        for (int c = 4; c <= 60; c++) begin
            @(posedge clk);
            @(negedge clk);
            if (overrun) ov++;
            if (rx_valid) begin
                k = c;
                break;
            end
        end
        checks++; if (ov != 0) begin errors++; $display("FAIL coinc_no_overrun: got %0d pulse cycles required 0", ov); end
        checks++; if (k != 20) begin errors++; $display("FAIL coinc_latency: got %0d required 20", k); end
        checks++; if (rx_data !== 11'h000) begin errors++; $display("FAIL coinc_data: got %h required 000", rx_data); end
        rx_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL coinc_drain: got %b required 0", rx_valid); end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        test_reset();
        test_clean();
        test_single_err();
        test_double_err();
        test_frame_err();
        test_reset_mid();
        test_overrun();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
